// File: rtl/alarm_event_reporter.sv
// Edge-detects the nine burglar_alarm lines, queues each new alarm as a numbered
// event on a valid/ready port, and drives a timed, acknowledgeable siren.

module alarm_zone_lane (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic load_sel,
  output logic pending,
  output logic rise,
  output logic ovf
);
  logic prev;

  assign rise = src & ~prev;
  // A re-trigger only counts as overrun if the old request is not leaving this cycle.
  assign ovf  = rise & pending & ~load_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      prev    <= src;
      pending <= (pending & ~load_sel) | rise;
    end
  end
endmodule

module alarm_event_reporter #(
  parameter int SIREN_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] alarmEnable,
  input  logic       garageAlarm,
  input  logic       ackIn,
  output logic       eventValid,
  input  logic       eventReady,
  output logic [3:0] eventZone,
  output logic [7:0] eventSeq,
  output logic       siren,
  output logic       overrun
);
  localparam int NUM_ZONES = 9;
  localparam int CW        = $clog2(SIREN_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(SIREN_CYCLES - 1);

  typedef struct packed {
    logic [3:0] zone;
    logic [7:0] seq;
  } event_t;

  typedef enum logic {QUIET, SOUNDING} siren_state_t;

  logic [NUM_ZONES-1:0] src;
  logic [NUM_ZONES-1:0] pending;
  logic [NUM_ZONES-1:0] rise;
  logic [NUM_ZONES-1:0] ovf;
  logic [NUM_ZONES-1:0] load_vec;
  logic [3:0]           sel_zone;
  logic                 load;
  logic                 any_rise;
  logic [7:0]           seq_cnt;
  event_t               ev_q;
  logic                 ev_vld;

  siren_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign src      = {garageAlarm, alarmEnable};
  assign any_rise = |rise;

  for (genvar g = 0; g < NUM_ZONES; g++) begin : g_zone
    assign load_vec[g] = load && (sel_zone == 4'(g));
    alarm_zone_lane u_lane (
      .clk      (clk),
      .reset    (reset),
      .src      (src[g]),
      .load_sel (load_vec[g]),
      .pending  (pending[g]),
      .rise     (rise[g]),
      .ovf      (ovf[g])
    );
  end

  // Scan downward so the lowest set bit (zone 0 highest priority) is kept.
  always_comb begin
    sel_zone = 4'd0;
    for (int i = NUM_ZONES - 1; i >= 0; i--) begin
      if (pending[i]) sel_zone = 4'(i);
    end
  end

  assign load = (!ev_vld || eventReady) && (|pending);

  always_ff @(posedge clk) begin
    if (reset) begin
      ev_vld  <= 1'b0;
      ev_q    <= '0;
      seq_cnt <= 8'd0;
    end else if (load) begin
      ev_vld  <= 1'b1;
      ev_q    <= '{zone: sel_zone, seq: seq_cnt};
      seq_cnt <= seq_cnt + 8'd1;
    end else if (eventReady) begin
      ev_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         overrun <= 1'b0;
    else if (ackIn)    overrun <= 1'b0;
    else if (|ovf)     overrun <= 1'b1;
  end

  assign eventValid = ev_vld;
  assign eventZone  = ev_q.zone;
  assign eventSeq   = ev_q.seq;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= QUIET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      QUIET: begin
        if (any_rise) begin
          state_d = SOUNDING;
          cnt_d   = RELOAD;
        end
      end
      SOUNDING: begin
        // Ack beats a coincident edge; the edge is still queued as an event.
        if (ackIn) begin
          state_d = QUIET;
          cnt_d   = '0;
        end else if (any_rise) begin
          cnt_d   = RELOAD;
        end else if (cnt_q == '0) begin
          state_d = QUIET;
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = QUIET;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    siren = (state_q == SOUNDING);
  end
endmodule
